// File: rtl/vending_pkg.sv
// Shared types and helpers for the multi-product vending core.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam int MONEY_W    = 12;
  localparam int STOCK_W    = 4;
  localparam int FLAT_MAX_W = 1024;

  // Returns item idx of a packed price vector whose fields are w bits wide (w <= 32).
  function automatic logic [31:0] price_slice(input logic [FLAT_MAX_W-1:0] flat,
                                              input int unsigned idx,
                                              input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return 32'(flat >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/vending_core_multi_stock.sv
// Per-item stock counters: decrement on sale, bulk reload on restock, sold_out flags.
module vend_stock_bank #(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dec_en,
  input  logic [$clog2(NUM_ITEMS)-1:0] dec_idx,
  input  logic                         restock,
  output logic [NUM_ITEMS-1:0]         sold_out
);

  localparam int IDX_W = $clog2(NUM_ITEMS);
  localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(INIT_STOCK);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];

  // Restock wins over a same-cycle sale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= INIT_VAL;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
        if (restock)
          stock_q[i] <= INIT_VAL;
        else if (dec_en && dec_idx == IDX_W'(i) && stock_q[i] != '0)
          stock_q[i] <= stock_q[i] - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
  end

endmodule

// File: rtl/vending_core_multi.sv
// Multi-product vending core: credit arithmetic, selection FSM, dispense timer, change payout.
// Optional idle refund timer enabled by defining VEND_IDLE_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no credit held
// CREDIT   | credit > 0, waiting for coin/select/cancel
// DISPENSE | dispense[idx] held while down-counter runs
// CHANGE   | one-cycle change payout, credit cleared on exit
module vending_core_multi #(
  parameter int NUM_ITEMS       = 4,
  parameter int MONEY_W         = vending_pkg::MONEY_W,
  parameter int STOCK_W         = vending_pkg::STOCK_W,
  parameter int INIT_STOCK      = 9,
  parameter int CREDIT_MAX      = 4095,
  parameter int DISPENSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           coin_valid,
  input  logic [MONEY_W-1:0]             coin_value,
  input  logic                           sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0]   sel_idx,
  input  logic                           cancel,
  input  logic                           restock,
  input  logic [NUM_ITEMS*MONEY_W-1:0]   price_flat,
  output logic [MONEY_W-1:0]             credit,
  output logic [NUM_ITEMS-1:0]           dispense,
  output logic [NUM_ITEMS-1:0]           sold_out,
  output logic                           change_valid,
  output logic [MONEY_W-1:0]             change_amt,
  output logic                           coin_reject,
  output logic                           err_sel,
  output logic                           busy
);

  import vending_pkg::*;

  localparam int IDX_W = $clog2(NUM_ITEMS);
  localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [MONEY_W:0]   CREDIT_LIMIT = (MONEY_W+1)'(CREDIT_MAX);
  localparam logic [IDX_W:0]     ITEMS_LIM    = (IDX_W+1)'(NUM_ITEMS);
  localparam logic [CNT_W-1:0]   DISP_LOAD    = CNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [NUM_ITEMS-1:0] ONE_HOT0   = NUM_ITEMS'(1);

  if (NUM_ITEMS < 2 || MONEY_W > 31 || DISPENSE_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      NUM_ITEMS * MONEY_W > FLAT_MAX_W ||
      64'(CREDIT_MAX) >= (64'd1 << MONEY_W)) begin : g_param_check
    $error("vending_core_multi: parameter out of range");
  end

  state_t                 state_q, state_d;
  logic [MONEY_W-1:0]     credit_q, credit_d;
  logic [MONEY_W-1:0]     change_amt_q, change_amt_d;
  logic [NUM_ITEMS-1:0]   dispense_q, dispense_d;
  logic [CNT_W-1:0]       disp_cnt_q, disp_cnt_d;
  logic                   change_valid_q, change_valid_d;
  logic                   coin_reject_q, coin_reject_d;
  logic                   err_sel_q, err_sel_d;
  logic                   busy_q, busy_d;
  logic                   stock_dec, stock_restock;
  logic [NUM_ITEMS-1:0]   sold_out_w;

  logic [FLAT_MAX_W-1:0]  price_ext;
  logic [MONEY_W-1:0]     sel_price;
  logic [MONEY_W:0]       coin_sum;
  logic                   coin_ok, sel_ok;

  assign price_ext = FLAT_MAX_W'(price_flat);
  assign sel_price = MONEY_W'(price_slice(price_ext, 32'(sel_idx), $unsigned(MONEY_W)));
  assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_ok   = (coin_sum <= CREDIT_LIMIT);
  assign sel_ok    = ({1'b0, sel_idx} < ITEMS_LIM) && !sold_out_w[sel_idx] &&
                     (credit_q >= sel_price);

`ifdef VEND_IDLE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      to_cnt_q <= '0;
    else if (to_clr || state_q != CREDIT)
      to_cnt_q <= '0;
    else if (to_cnt_q != TO_LIMIT)
      to_cnt_q <= to_cnt_q + TO_W'(1);
  end
`endif

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    change_amt_d   = change_amt_q;
    dispense_d     = dispense_q;
    disp_cnt_d     = disp_cnt_q;
    change_valid_d = 1'b0;
    coin_reject_d  = 1'b0;
    err_sel_d      = 1'b0;
    stock_dec      = 1'b0;
    stock_restock  = 1'b0;
`ifdef VEND_IDLE_TIMEOUT_EN
    to_clr         = 1'b0;
`endif
    case (state_q)
      IDLE, CREDIT: begin
        stock_restock = restock;
        if (cancel && state_q == CREDIT) begin
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
          coin_reject_d  = coin_valid;
        end else if (sel_valid) begin
          coin_reject_d = coin_valid;
          if (sel_ok) begin
            credit_d   = credit_q - sel_price;
            stock_dec  = 1'b1;
            dispense_d = ONE_HOT0 << sel_idx;
            disp_cnt_d = DISP_LOAD;
            state_d    = DISPENSE;
          end else begin
            err_sel_d = 1'b1;
`ifdef VEND_IDLE_TIMEOUT_EN
            to_clr    = 1'b1;
`endif
          end
        end else if (coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[MONEY_W-1:0];
            state_d  = (coin_sum != '0) ? CREDIT : IDLE;
`ifdef VEND_IDLE_TIMEOUT_EN
            to_clr   = 1'b1;
`endif
          end else begin
            coin_reject_d = 1'b1;
          end
        end
`ifdef VEND_IDLE_TIMEOUT_EN
        else if (state_q == CREDIT && to_cnt_q == TO_LIMIT) begin
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          change_amt_d   = credit_q;
        end
`endif
      end
      DISPENSE: begin
        coin_reject_d = coin_valid;
        if (disp_cnt_q == '0) begin
          dispense_d = '0;
          if (credit_q != '0) begin
            state_d        = CHANGE;
            change_valid_d = 1'b1;
            change_amt_d   = credit_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          disp_cnt_d = disp_cnt_q - CNT_W'(1);
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        credit_d      = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      change_amt_q   <= '0;
      dispense_q     <= '0;
      disp_cnt_q     <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      err_sel_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_amt_q   <= change_amt_d;
      dispense_q     <= dispense_d;
      disp_cnt_q     <= disp_cnt_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
      err_sel_q      <= err_sel_d;
      busy_q         <= busy_d;
    end
  end

  vend_stock_bank #(
    .NUM_ITEMS  (NUM_ITEMS),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk      (clk),
    .reset    (reset),
    .dec_en   (stock_dec),
    .dec_idx  (sel_idx),
    .restock  (stock_restock),
    .sold_out (sold_out_w)
  );

  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign sold_out     = sold_out_w;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign coin_reject  = coin_reject_q;
  assign err_sel      = err_sel_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_core_multi.sv
// Self-checking bench for vending_core_multi: transaction-level model plus directed scenarios.
module tb_vending_core_multi;

  localparam int N   = 4;
  localparam int MW  = 12;
  localparam int DC  = 4;
  localparam int TO  = 20;
  localparam int CMAX = 4095;
  localparam int INIT = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          coin_valid = 1'b0;
  logic [MW-1:0] coin_value = '0;
  logic          sel_valid = 1'b0;
  logic [1:0]    sel_idx = '0;
  logic          cancel = 1'b0;
  logic          restock = 1'b0;
  logic [N*MW-1:0] price_flat;
  logic [MW-1:0] credit;
  logic [N-1:0]  dispense;
  logic [N-1:0]  sold_out;
  logic          change_valid;
  logic [MW-1:0] change_amt;
  logic          coin_reject;
  logic          err_sel;
  logic          busy;

  int price [N] = '{0, 100, 75, 200};
  int n_pass = 0;
  int n_total = 0;

  assign price_flat = {MW'(price[3]), MW'(price[2]), MW'(price[1]), MW'(price[0])};

  always #5 clk = ~clk;

  vending_core_multi #(
    .NUM_ITEMS(N), .MONEY_W(MW), .STOCK_W(4), .INIT_STOCK(INIT),
    .CREDIT_MAX(CMAX), .DISPENSE_CYCLES(DC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .restock(restock),
    .price_flat(price_flat), .credit(credit), .dispense(dispense), .sold_out(sold_out),
    .change_valid(change_valid), .change_amt(change_amt), .coin_reject(coin_reject),
    .err_sel(err_sel), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  // Transaction-level model: money and stock as integers, a remaining-dispense count,
  // and a pending-refund flag.
  int m_credit = 0;
  int m_stock [N] = '{INIT, INIT, INIT, INIT};
  int m_item = 0;
  int m_left = 0;
  bit m_chg = 0;
  int m_chg_amt = 0;
  bit m_rej = 0;
  bit m_err = 0;
  int m_idle = 0;

  task automatic model_step();
    bit was_credit;
    bit clr;
    was_credit = (m_chg == 0 && m_left == 0 && m_credit > 0);
    clr = 0;
    m_rej = 0;
    m_err = 0;
    if (m_chg) begin
      m_chg = 0;
      m_credit = 0;
      m_rej = coin_valid;
    end else if (m_left > 0) begin
      m_rej = coin_valid;
      m_left--;
      if (m_left == 0 && m_credit > 0) begin
        m_chg = 1;
        m_chg_amt = m_credit;
      end
    end else begin
      if (cancel && m_credit > 0) begin
        m_chg = 1;
        m_chg_amt = m_credit;
        m_rej = coin_valid;
      end else if (sel_valid) begin
        m_rej = coin_valid;
        if (int'(sel_idx) < N && m_stock[sel_idx] > 0 && m_credit >= price[sel_idx]) begin
          m_credit -= price[sel_idx];
          m_stock[sel_idx]--;
          m_item = int'(sel_idx);
          m_left = DC;
        end else begin
          m_err = 1;
          clr = 1;
        end
      end else if (coin_valid) begin
        if (m_credit + int'(coin_value) <= CMAX) begin
          m_credit += int'(coin_value);
          clr = 1;
        end else begin
          m_rej = 1;
        end
      end
`ifdef VEND_IDLE_TIMEOUT_EN
      else if (m_credit > 0 && m_idle == TO) begin
        m_chg = 1;
        m_chg_amt = m_credit;
      end
`endif
      if (restock) for (int i = 0; i < N; i++) m_stock[i] = INIT;
    end
    if (!was_credit || clr) m_idle = 0;
    else if (m_idle < TO) m_idle++;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_credit = 0;
      for (int i = 0; i < N; i++) m_stock[i] = INIT;
      m_left = 0; m_chg = 0; m_rej = 0; m_err = 0; m_idle = 0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      logic [N-1:0] e_disp;
      logic [N-1:0] e_sold;
      e_disp = (m_left > 0) ? N'(1 << m_item) : '0;
      for (int i = 0; i < N; i++) e_sold[i] = (m_stock[i] == 0);
      check("credit", 32'(credit), 32'(m_credit));
      check("dispense", 32'(dispense), 32'(e_disp));
      check("sold_out", 32'(sold_out), 32'(e_sold));
      check("change_valid", 32'(change_valid), 32'(m_chg));
      if (m_chg) check("change_amt", 32'(change_amt), 32'(m_chg_amt));
      check("coin_reject", 32'(coin_reject), 32'(m_rej));
      check("err_sel", 32'(err_sel), 32'(m_err));
      check("busy", 32'(busy), 32'(m_left > 0 || m_chg));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit cv, input int val, input bit sv, input int idx,
                      input bit can, input bit rs);
    coin_valid = cv; coin_value = MW'(val);
    sel_valid = sv; sel_idx = 2'(idx);
    cancel = can; restock = rs;
    tick();
    coin_valid = 0; coin_value = '0; sel_valid = 0; sel_idx = '0; cancel = 0; restock = 0;
  endtask

  task automatic coin(input int v);  step(1, v, 0, 0, 0, 0); endtask
  task automatic sel(input int i);   step(0, 0, 1, i, 0, 0); endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("reset_credit", 32'(credit), 32'd0);
    check("reset_sold_out", 32'(sold_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Scenario 1: 50+50+25, buy item 1 at 100, expect 25 change.
    coin(50); coin(50); coin(25);
    check("t1_credit125", 32'(credit), 32'd125);
    sel(1);
    n = 0;
    for (int k = 0; k < 10 && dispense[1]; k++) begin
      n++;
      tick();
    end
    check("t1_disp_cycles", 32'(n), 32'd4);
    check("t1_change_valid", 32'(change_valid), 32'd1);
    check("t1_change_amt", 32'(change_amt), 32'd25);
    tick();
    check("t1_credit_zero", 32'(credit), 32'd0);

    // Scenario 2: overflow coin rejected, cancel refunds everything.
    coin(4000);
    coin(100);
    check("t2_reject", 32'(coin_reject), 32'd1);
    check("t2_credit_kept", 32'(credit), 32'd4000);
    step(0, 0, 0, 0, 1, 0);
    check("t2_refund", 32'(change_amt), 32'd4000);
    tick();
    check("t2_idle", 32'(busy), 32'd0);

    // Scenario 3: deplete free item 0, then restock.
    for (int k = 0; k < 9; k++) begin
      sel(0);
      repeat (DC) tick();
    end
    check("t3_sold_out", 32'(sold_out[0]), 32'd1);
    sel(0);
    check("t3_err_sel", 32'(err_sel), 32'd1);
    check("t3_no_disp", 32'(dispense), 32'd0);
    step(0, 0, 0, 0, 0, 1);
    check("t3_restocked", 32'(sold_out[0]), 32'd0);

    // Scenario 4: insufficient credit, then coin during dispense.
    coin(30);
    sel(2);
    check("t4_err_sel", 32'(err_sel), 32'd1);
    check("t4_credit30", 32'(credit), 32'd30);
    coin(70);
    sel(1);
    coin(5);
    check("t4_disp_reject", 32'(coin_reject), 32'd1);
    repeat (DC + 1) tick();

    // Scenario 5: cancel beats select and coin; reset mid-dispense.
    coin(60);
    step(1, 10, 1, 1, 1, 0);
    check("t5_refund60", 32'(change_amt), 32'd60);
    check("t5_coin_rej", 32'(coin_reject), 32'd1);
    check("t5_no_disp", 32'(dispense), 32'd0);
    tick();
    coin(100);
    sel(1);
    tick();
    #2 reset = 1;
    #1;
    check("t5_rst_disp", 32'(dispense), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_credit", 32'(credit), 32'd0);
    check("t5_rst_chg", 32'(change_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Scenario 6: idle refund timer.
    coin(10);
`ifdef VEND_IDLE_TIMEOUT_EN
    n = 0;
    for (int k = 0; k < 2 * TO + 10 && !change_valid; k++) tick();
    check("t6_timeout_fired", 32'(change_valid), 32'd1);
    check("t6_timeout_amt", 32'(change_amt), 32'd10);
`else
    repeat (TO + 10) tick();
    check("t6_credit_held", 32'(credit), 32'd10);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
